// File: rtl/accum_seq_ctrl.sv
// Control-word sequencer for the MVU BRAM accumulator bank: queues accumulate
// instructions and emits one {valid, op, size} word per dot-product beat.
module accum_seq_ctrl #(
  parameter int NUM_ACCUM = 8,
  parameter int ACCIDW    = 4,
  parameter int STEPW     = 16,
  parameter int QDEPTH    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  output logic              inst_ready,
  input  logic [ACCIDW-1:0] inst_size,
  input  logic [STEPW-1:0]  inst_steps,
  input  logic              beat_valid,
  output logic [ACCIDW+2:0] accum_ctrl,
  output logic              inst_done,
  output logic              beat_err,
  output logic              inst_err,
  output logic              busy
);

  localparam int PW = $clog2(QDEPTH);
  localparam logic [ACCIDW:0] MAXSZ = (ACCIDW+1)'(NUM_ACCUM);

  localparam logic [1:0] OP_SET    = 2'd0;
  localparam logic [1:0] OP_UPD    = 2'd1;
  localparam logic [1:0] OP_WB     = 2'd2;
  localparam logic [1:0] OP_SET_WB = 2'd3;

  typedef struct packed {
    logic [ACCIDW-1:0] size;
    logic [STEPW-1:0]  steps;
  } inst_t;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nx;
  inst_t             q_mem [QDEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [PW:0]       q_cnt;
  logic              q_empty, q_full, push, pop, load;
  inst_t             head, act;
  logic              head_ok;
  logic [ACCIDW-1:0] ent_cnt;
  logic [STEPW-1:0]  step_cnt;
  logic              beat_fire, ent_last, step_last, last;
  logic [1:0]        op;

  // ---------------- instruction queue ----------------
  assign q_empty    = (q_cnt == '0);
  assign q_full     = (q_cnt == (PW+1)'(QDEPTH));
  assign inst_ready = !q_full && !rst;
  assign push       = inst_valid && inst_ready;
  assign head       = q_mem[rd_ptr];
  assign head_ok    = (head.size != '0) && ({1'b0, head.size} <= MAXSZ) && (head.steps != '0);

  always_ff @(posedge clk) begin
    if (push) q_mem[wr_ptr] <= '{size: inst_size, steps: inst_steps};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // ---------------- beat tracking ----------------
  assign beat_fire = beat_valid && (state == RUN);
  assign ent_last  = (ent_cnt == act.size - ACCIDW'(1));
  assign step_last = (step_cnt == act.steps - STEPW'(1));
  assign last      = beat_fire && ent_last && step_last;

  always_comb begin
    op = OP_UPD;
    if (act.steps == STEPW'(1))  op = OP_SET_WB;
    else if (step_cnt == '0)     op = OP_SET;
    else if (step_last)          op = OP_WB;
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // A pop on the last beat gives zero-bubble hand-over; illegal heads are popped and dropped.
  always_comb begin
    state_nx = state;
    pop      = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE: begin
        if (!q_empty) begin
          pop  = 1'b1;
          load = head_ok;
          if (head_ok) state_nx = RUN;
        end
      end
      RUN: begin
        if (last) begin
          if (!q_empty) begin
            pop      = 1'b1;
            load     = head_ok;
            state_nx = head_ok ? RUN : IDLE;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act      <= '0;
      ent_cnt  <= '0;
      step_cnt <= '0;
    end else if (load) begin
      act      <= head;
      ent_cnt  <= '0;
      step_cnt <= '0;
    end else if (beat_fire) begin
      if (ent_last) begin
        ent_cnt  <= '0;
        step_cnt <= step_last ? '0 : step_cnt + 1'b1;
      end else begin
        ent_cnt  <= ent_cnt + 1'b1;
      end
    end
  end

  // ---------------- registered outputs ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accum_ctrl <= '0;
      inst_done  <= 1'b0;
      beat_err   <= 1'b0;
      inst_err   <= 1'b0;
    end else begin
      accum_ctrl <= beat_fire ? {1'b1, op, act.size} : '0;
      inst_done  <= last;
      beat_err   <= beat_valid && (state == IDLE);
      inst_err   <= pop && !head_ok;
    end
  end

  assign busy = (state == RUN) || !q_empty;

endmodule

// File: tb/tb_accum_seq_ctrl.sv
// Directed bench for accum_seq_ctrl: hand-computed control words, queue
// back-pressure, illegal instructions, stray beats and mid-instruction reset.
module tb_accum_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [3:0]  inst_size;
  logic [15:0] inst_steps;
  logic        beat_valid;
  logic [6:0]  accum_ctrl;
  logic        inst_done, beat_err, inst_err, busy;

  int vectors = 0;
  int miscompares = 0;

  accum_seq_ctrl #(.NUM_ACCUM(8), .ACCIDW(4), .STEPW(16), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_size(inst_size), .inst_steps(inst_steps),
    .beat_valid(beat_valid), .accum_ctrl(accum_ctrl),
    .inst_done(inst_done), .beat_err(beat_err), .inst_err(inst_err), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] cw(input logic [1:0] op, input logic [3:0] sz);
    return {1'b1, op, sz};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] sz, input logic [15:0] st);
    inst_valid = 1'b1;
    inst_size  = sz;
    inst_steps = st;
    tick();
    inst_valid = 1'b0;
  endtask

  initial begin
    logic [1:0] ops2 [6];
    logic [6:0] exp3 [7];
    ops2 = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    exp3 = '{7'h40|7'd3, 7'h40|7'd3, 7'h40|7'd3, 7'h60|7'd3, 7'h60|7'd3, 7'h60|7'd3, 7'h70|7'd1};

    rst = 1'b1; inst_valid = 1'b0; inst_size = '0; inst_steps = '0; beat_valid = 1'b0;
    #12;
    chk("rst_ctrl", 32'(accum_ctrl), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_flags", 32'({inst_done, beat_err, inst_err}), 0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("rst_ready", 32'(inst_ready), 1);

    // size=4, steps=1
    push(4'd4, 16'd1);
    chk("t1_busy_q", 32'(busy), 1);
    tick();
    beat_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t1_ctrl", 32'(accum_ctrl), 32'(cw(2'd3, 4'd4)));
      chk("t1_done", 32'(inst_done), 32'(i == 3));
    end
    chk("t1_busy_end", 32'(busy), 0);
    beat_valid = 1'b0;
    tick();
    chk("t1_idle_ctrl", 32'(accum_ctrl), 0);
    chk("t1_idle_done", 32'(inst_done), 0);

    // size=2, steps=3
    push(4'd2, 16'd3);
    tick();
    beat_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t2_ctrl", 32'(accum_ctrl), 32'(cw(ops2[i], 4'd2)));
      chk("t2_done", 32'(inst_done), 32'(i == 5));
    end
    beat_valid = 1'b0;
    tick();

    // back-to-back (3,2) then (1,1)
    push(4'd3, 16'd2);
    push(4'd1, 16'd1);
    beat_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t3_ctrl", 32'(accum_ctrl), 32'(exp3[i]));
      chk("t3_done", 32'(inst_done), 32'(i == 5 || i == 6));
    end
    beat_valid = 1'b0;
    chk("t3_busy_end", 32'(busy), 0);
    tick();

    // queue fill: first entry moves to active, so five pushes fill four slots
    inst_valid = 1'b1; inst_size = 4'd1; inst_steps = 16'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_ready", 32'(inst_ready), 32'(i != 4));
    end
    tick();
    chk("t4_hold", 32'(inst_ready), 0);
    beat_valid = 1'b1;
    tick();
    beat_valid = 1'b0;
    chk("t4_pop_ctrl", 32'(accum_ctrl), 32'(cw(2'd3, 4'd1)));
    chk("t4_pop_ready", 32'(inst_ready), 1);
    tick();
    inst_valid = 1'b0;
    chk("t4_refill", 32'(inst_ready), 0);
    beat_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_drain", 32'(accum_ctrl), 32'(cw(2'd3, 4'd1)));
      chk("t4_done", 32'(inst_done), 1);
    end
    beat_valid = 1'b0;
    chk("t4_busy_end", 32'(busy), 0);
    tick();

    // illegal size=0, then (1,1) with a beat before it loads
    push(4'd0, 16'd5);
    push(4'd1, 16'd1);
    chk("t5_inst_err", 32'(inst_err), 1);
    beat_valid = 1'b1;
    tick();
    chk("t5_beat_err", 32'(beat_err), 1);
    chk("t5_noval", 32'(accum_ctrl), 0);
    chk("t5_err_clr", 32'(inst_err), 0);
    tick();
    beat_valid = 1'b0;
    chk("t5_ctrl", 32'(accum_ctrl), 32'(cw(2'd3, 4'd1)));
    chk("t5_done", 32'(inst_done), 1);
    chk("t5_berr_clr", 32'(beat_err), 0);
    tick();

    // reset mid-instruction
    push(4'd1, 16'd3);
    tick();
    beat_valid = 1'b1;
    tick();
    chk("t6_pre_ctrl", 32'(accum_ctrl), 32'(cw(2'd0, 4'd1)));
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_ctrl", 32'(accum_ctrl), 0);
    chk("t6_rst_busy", 32'(busy), 0);
    chk("t6_rst_done", 32'(inst_done), 0);
    beat_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    chk("t6_ready", 32'(inst_ready), 1);
    push(4'd2, 16'd2);
    tick();
    beat_valid = 1'b1;
    tick();
    chk("t6_set", 32'(accum_ctrl), 32'(cw(2'd0, 4'd2)));
    tick(); tick(); tick();
    beat_valid = 1'b0;
    chk("t6_wb", 32'(accum_ctrl), 32'(cw(2'd2, 4'd2)));
    chk("t6_done", 32'(inst_done), 1);
    tick();
    chk("t6_busy_end", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
